// File: rtl/mult_stream_engine.sv
// FIFO-fed iterative shift-add multiplier; products leave on a valid/ready handshake.
// Optional macro MULT_SIGNED_EN: two's-complement operands, adds one FIX cycle.
module mult_stream_engine #(
    parameter  int W     = 8,
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           wr_en,
    input  logic [2*W-1:0] wr_data,
    output logic           full,
    output logic [AW:0]    level,
    output logic           overflow_err,
    output logic           busy,
    output logic           prod_valid,
    input  logic           prod_ready,
    output logic [2*W-1:0] product
);
    localparam int CW = $clog2(W) + 1;

`ifdef MULT_SIGNED_EN
    typedef enum logic [2:0] {IDLE, LOAD, CALC, FIX, HOLD} state_t;
`else
    typedef enum logic [1:0] {IDLE, LOAD, CALC, HOLD} state_t;
`endif

    state_t         state_q;
    logic [2*W-1:0] mem [DEPTH];
    logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [AW:0]    level_q, level_d;
    logic [2*W-1:0] rd_data_q;
    logic           overflow_q;
    logic [2*W-1:0] mcand_q, acc_q, acc_d, product_q;
    logic [W-1:0]   mplr_q;
    logic [CW-1:0]  cnt_q;
    logic           prod_valid_q;
    logic           wr_acc, pop;
    logic [W-1:0]   op_a, op_b;

    assign full         = (level_q == (AW+1)'(DEPTH));
    assign level        = level_q;
    assign overflow_err = overflow_q;
    assign busy         = (state_q != IDLE);
    assign prod_valid   = prod_valid_q;
    assign product      = product_q;

    // A write while full is dropped even if a pop frees a slot in the same cycle.
    assign wr_acc = wr_en && !full;
    assign pop    = (state_q == IDLE) && (level_q != '0);

    always_comb begin
        level_d = level_q;
        if (wr_acc && !pop)      level_d = level_q + 1'b1;
        else if (!wr_acc && pop) level_d = level_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (wr_acc) mem[wr_ptr_q] <= wr_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            rd_data_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            level_q <= level_d;
            if (wr_acc) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop) begin
                rd_data_q <= mem[rd_ptr_q];
                rd_ptr_q  <= rd_ptr_q + 1'b1;
            end
            if (wr_en && full) overflow_q <= 1'b1;
        end
    end

`ifdef MULT_SIGNED_EN
    logic sign_q;
    assign op_a = rd_data_q[2*W-1] ? (~rd_data_q[2*W-1:W] + 1'b1) : rd_data_q[2*W-1:W];
    assign op_b = rd_data_q[W-1]   ? (~rd_data_q[W-1:0] + 1'b1)   : rd_data_q[W-1:0];
`else
    assign op_a = rd_data_q[2*W-1:W];
    assign op_b = rd_data_q[W-1:0];
`endif

    assign acc_d = acc_q + (mplr_q[0] ? mcand_q : '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            mcand_q      <= '0;
            mplr_q       <= '0;
            acc_q        <= '0;
            cnt_q        <= '0;
            product_q    <= '0;
            prod_valid_q <= 1'b0;
`ifdef MULT_SIGNED_EN
            sign_q       <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: if (pop) state_q <= LOAD;
                LOAD: begin
                    mcand_q <= {{W{1'b0}}, op_a};
                    mplr_q  <= op_b;
                    acc_q   <= '0;
                    cnt_q   <= '0;
`ifdef MULT_SIGNED_EN
                    sign_q  <= rd_data_q[2*W-1] ^ rd_data_q[W-1];
`endif
                    state_q <= CALC;
                end
                CALC: begin
                    acc_q   <= acc_d;
                    mcand_q <= mcand_q << 1;
                    mplr_q  <= mplr_q >> 1;
                    cnt_q   <= cnt_q + 1'b1;
                    if (cnt_q == CW'(W-1)) begin
`ifdef MULT_SIGNED_EN
                        state_q <= FIX;
`else
                        product_q    <= acc_d;
                        prod_valid_q <= 1'b1;
                        state_q      <= HOLD;
`endif
                    end
                end
`ifdef MULT_SIGNED_EN
                // Magnitude of -2^(W-1) squared is 2^(2W-2), which still fits unsigned in 2W bits.
                FIX: begin
                    product_q    <= sign_q ? (~acc_q + 1'b1) : acc_q;
                    prod_valid_q <= 1'b1;
                    state_q      <= HOLD;
                end
`endif
                HOLD: if (prod_ready) begin
                    prod_valid_q <= 1'b0;
                    state_q      <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mult_stream_engine.sv
// Randomised self-checking bench for mult_stream_engine against a queue-based product model.
module tb_mult_stream_engine;
    localparam int W     = 8;
    localparam int DEPTH = 16;
    localparam int AW    = $clog2(DEPTH);
`ifdef MULT_SIGNED_EN
    localparam int LAT = W + 4;
`else
    localparam int LAT = W + 3;
`endif

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           wr_en = 1'b0;
    logic [2*W-1:0] wr_data = '0;
    logic           full, overflow_err, busy, prod_valid;
    logic           prod_ready = 1'b0;
    logic [AW:0]    level;
    logic [2*W-1:0] product;

    int checks = 0;
    int errors = 0;
    logic [2*W-1:0] exp_q [$];

    mult_stream_engine #(.W(W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
        .full(full), .level(level), .overflow_err(overflow_err), .busy(busy),
        .prod_valid(prod_valid), .prod_ready(prod_ready), .product(product)
    );

    always #5 clk = ~clk;

    function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
        longint pa, pb;
`ifdef MULT_SIGNED_EN
        pa = longint'($signed(a));
        pb = longint'($signed(b));
`else
        pa = longint'(a);
        pb = longint'(b);
`endif
        return (2*W)'(pa * pb);
    endfunction

    task automatic do_reset();
        @(negedge clk) rst = 1'b1;
        wr_en = 1'b0;
        @(negedge clk) rst = 1'b0;
        exp_q.delete();
    endtask

    task automatic write_one(input logic [2*W-1:0] d);
        @(negedge clk);
        wr_en = 1'b1;
        wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({full, level, overflow_err, busy, prod_valid, product} !== '0) begin
            errors++;
            $display("FAIL reset_state: got full=%b level=%0d ovf=%b busy=%b valid=%b prod=%h, want all 0",
                     full, level, overflow_err, busy, prod_valid, product);
        end
        prod_ready = 1'b0;
        for (int i = 0; i < 3; i++) write_one({W'(i + 3), W'(i + 5)});
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        checks++;
        if ({full, level, overflow_err, busy, prod_valid, product} !== '0) begin
            errors++;
            $display("FAIL reset_mid: got level=%0d busy=%b valid=%b prod=%h, want all 0",
                     level, busy, prod_valid, product);
        end
        begin
            int seen = 0;
            for (int i = 0; i < 40; i++) begin
                @(negedge clk);
                if (prod_valid || busy || level != 0) seen++;
            end
            checks++;
            if (seen != 0) begin
                errors++;
                $display("FAIL reset_quiet: %0d active cycles after reset, want 0", seen);
            end
        end
    endtask

    task automatic test_latency();
        logic [2*W-1:0] e;
        prod_ready = 1'b1;
        e = ref_mul(8'd13, 8'd11);
        @(negedge clk);
        wr_en = 1'b1;
        wr_data = {8'd13, 8'd11};
        @(negedge clk);
        wr_en = 1'b0;
        repeat (LAT - 2) @(negedge clk);
        checks++;
        if (prod_valid !== 1'b0) begin
            errors++;
            $display("FAIL latency_early: valid=%b after edge %0d, want 0", prod_valid, LAT - 1);
        end
        @(negedge clk);
        checks++;
        if (prod_valid !== 1'b1 || product !== e) begin
            errors++;
            $display("FAIL latency_valid: valid=%b prod=%0d after edge %0d, want 1/%0d", prod_valid, product, LAT, e);
        end
        @(negedge clk);
        checks++;
        if (prod_valid !== 1'b0 || product !== e) begin
            errors++;
            $display("FAIL latency_single: valid=%b prod=%0d, want 0/%0d", prod_valid, product, e);
        end
    endtask

    task automatic test_patterns();
        logic [2*W-1:0] pats [4];
        logic [2*W-1:0] fixed [4];
`ifdef MULT_SIGNED_EN
        pats  = '{16'hFF02, 16'h8080, 16'h7F80, 16'hFFFF};
        fixed = '{16'hFFFE, 16'h4000, 16'hC080, 16'h0001};
`else
        pats  = '{16'hFFFF, 16'h00C8, 16'h8080, 16'h01FF};
        fixed = '{16'hFE01, 16'h0000, 16'h4000, 16'h00FF};
`endif
        prod_ready = 1'b1;
        for (int i = 0; i < 4 + 6; i++) begin
            logic [2*W-1:0] d, e;
            int n;
            if (i < 4) begin
                d = pats[i];
                e = fixed[i];
            end else begin
                d = (2*W)'($urandom);
                e = ref_mul(d[2*W-1:W], d[W-1:0]);
            end
            write_one(d);
            n = 0;
            while (prod_valid !== 1'b1 && n < 50) begin
                @(negedge clk);
                n++;
            end
            checks++;
            if (prod_valid !== 1'b1 || product !== e) begin
                errors++;
                $display("FAIL pattern_%0d: op=%h valid=%b prod=%h, want %h", i, d, prod_valid, product, e);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_hold_stable();
        logic [2*W-1:0] d, e;
        int n, bad;
        do_reset();
        prod_ready = 1'b0;
        d = (2*W)'($urandom);
        e = ref_mul(d[2*W-1:W], d[W-1:0]);
        write_one(d);
        n = 0;
        while (prod_valid !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (prod_valid !== 1'b1 || product !== e || busy !== 1'b1 || level !== '0) bad++;
            @(negedge clk);
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL hold_stable: %0d unstable cycles, prod=%h want %h", bad, product, e);
        end
        prod_ready = 1'b1;
        @(negedge clk);
        prod_ready = 1'b0;
        checks++;
        if (prod_valid !== 1'b0 || busy !== 1'b0 || product !== e) begin
            errors++;
            $display("FAIL hold_release: valid=%b busy=%b prod=%h, want 0/0/%h", prod_valid, busy, product, e);
        end
    endtask

    task automatic test_overflow();
        logic [2*W-1:0] d;
        int n;
        do_reset();
        prod_ready = 1'b0;
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            if (i == 17) begin
                checks++;
                if (level !== (AW+1)'(16) || full !== 1'b1 || overflow_err !== 1'b0) begin
                    errors++;
                    $display("FAIL ovf_fill: level=%0d full=%b ovf=%b, want 16/1/0", level, full, overflow_err);
                end
            end
            d = (2*W)'($urandom);
            wr_en = 1'b1;
            wr_data = d;
            if (i < 17) exp_q.push_back(ref_mul(d[2*W-1:W], d[W-1:0]));
        end
        @(negedge clk);
        wr_en = 1'b0;
        checks++;
        if (level !== (AW+1)'(16) || full !== 1'b1 || overflow_err !== 1'b1) begin
            errors++;
            $display("FAIL ovf_drop: level=%0d full=%b ovf=%b, want 16/1/1", level, full, overflow_err);
        end
        n = 0;
        while (exp_q.size() != 0 && n < 17 * 30) begin
            @(negedge clk);
            n++;
            prod_ready = prod_valid;
            if (prod_valid === 1'b1) begin
                checks++;
                if (product !== exp_q[0]) begin
                    errors++;
                    $display("FAIL ovf_order: prod=%h, want %h", product, exp_q[0]);
                end
                void'(exp_q.pop_front());
            end
        end
        @(negedge clk);
        prod_ready = 1'b0;
        checks++;
        if (exp_q.size() != 0 || overflow_err !== 1'b1 || level !== '0) begin
            errors++;
            $display("FAIL ovf_drain: left=%0d ovf=%b level=%0d, want 0/1/0", exp_q.size(), overflow_err, level);
        end
    endtask

    task automatic test_random_stream();
        logic [2*W-1:0] d;
        int n;
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            prod_ready = ($urandom_range(0, 1) == 1);
            if (prod_valid === 1'b1 && prod_ready) begin
                checks++;
                if (exp_q.size() == 0 || product !== exp_q[0]) begin
                    errors++;
                    $display("FAIL stream: prod=%h, want %h", product, exp_q.size() ? exp_q[0] : '0);
                end
                if (exp_q.size() != 0) void'(exp_q.pop_front());
            end
            wr_en = 1'b0;
            if ($urandom_range(0, 7) == 0 && exp_q.size() < DEPTH - 2) begin
                d = (2*W)'($urandom);
                wr_en = 1'b1;
                wr_data = d;
                exp_q.push_back(ref_mul(d[2*W-1:W], d[W-1:0]));
            end
        end
        @(negedge clk);
        wr_en = 1'b0;
        n = 0;
        prod_ready = 1'b1;
        while (exp_q.size() != 0 && n < DEPTH * 30) begin
            @(negedge clk);
            n++;
            if (prod_valid === 1'b1) begin
                checks++;
                if (product !== exp_q[0]) begin
                    errors++;
                    $display("FAIL stream_drain: prod=%h, want %h", product, exp_q[0]);
                end
                void'(exp_q.pop_front());
            end
        end
        prod_ready = 1'b0;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL stream_timeout: %0d products outstanding, want 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_patterns();
        test_hold_stable();
        test_overflow();
        test_random_stream();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
